// File: rtl/exec_unit.sv
// PIC10F200-style execute unit: fetches one instruction word, reads the addressed file
// register, then produces the ALU result, the file write strobe, and W/STATUS updates.
//
// state | meaning
// IDLE  | ready=1, wait for instr_valid and latch the instruction word
// READ  | present addr=f so ram_bus carries the file value in the next cycle
// EXEC  | combine ram_bus/W/k, drive we/alu_bus/done/skip, commit W and STATUS
module exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] instr,
  input  logic        instr_valid,
  output logic        ready,
  input  logic [7:0]  ram_bus,
  output logic [4:0]  addr,
  output logic        we,
  output logic [7:0]  alu_bus,
  output logic [7:0]  w_out,
  output logic [2:0]  status_out,
  output logic        done,
  output logic        skip
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC
  } state_e;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_MOVWF,
    OP_CLR,
    OP_SUBWF,
    OP_DECF,
    OP_IORWF,
    OP_ANDWF,
    OP_XORWF,
    OP_ADDWF,
    OP_MOVF,
    OP_COMF,
    OP_INCF,
    OP_DECFSZ,
    OP_RRF,
    OP_RLF,
    OP_SWAPF,
    OP_INCFSZ,
    OP_BCF,
    OP_BSF,
    OP_BTFSC,
    OP_BTFSS,
    OP_MOVLW,
    OP_IORLW,
    OP_ANDLW,
    OP_XORLW
  } op_e;

  state_e      state_q, state_d;
  logic [11:0] instr_q, instr_d;
  logic [7:0]  w_q, w_d;
  logic [2:0]  status_q, status_d;

  op_e         op;
  logic [7:0]  lit_k;
  logic        dst_d;
  logic [7:0]  bit_mask;
  logic [7:0]  res;
  logic [8:0]  sum9;
  logic [4:0]  sum5;
  logic        c_nx;
  logic        dc_nx;
  logic        upd_z;
  logic        upd_dc;
  logic        upd_c;
  logic        to_f;
  logic        to_w;
  logic        skip_c;
  logic [2:0]  status_nx;

  assign lit_k    = instr_q[7:0];
  assign dst_d    = instr_q[5];
  assign bit_mask = 8'h01 << instr_q[7:5];
  assign w_out      = w_q;
  assign status_out = status_q;

  // Decode: the top two bits split byte-oriented, bit-oriented, control and literal groups.
  always_comb begin
    op = OP_NOP;
    case (instr_q[11:10])
      2'b00: begin
        case (instr_q[9:6])
          4'b0000: op = dst_d ? OP_MOVWF : OP_NOP;
          4'b0001: op = OP_CLR;
          4'b0010: op = OP_SUBWF;
          4'b0011: op = OP_DECF;
          4'b0100: op = OP_IORWF;
          4'b0101: op = OP_ANDWF;
          4'b0110: op = OP_XORWF;
          4'b0111: op = OP_ADDWF;
          4'b1000: op = OP_MOVF;
          4'b1001: op = OP_COMF;
          4'b1010: op = OP_INCF;
          4'b1011: op = OP_DECFSZ;
          4'b1100: op = OP_RRF;
          4'b1101: op = OP_RLF;
          4'b1110: op = OP_SWAPF;
          default: op = OP_INCFSZ;
        endcase
      end
      2'b01: begin
        case (instr_q[9:8])
          2'b00:   op = OP_BCF;
          2'b01:   op = OP_BSF;
          2'b10:   op = OP_BTFSC;
          default: op = OP_BTFSS;
        endcase
      end
      2'b11: begin
        case (instr_q[9:8])
          2'b00:   op = OP_MOVLW;
          2'b01:   op = OP_IORLW;
          2'b10:   op = OP_ANDLW;
          default: op = OP_XORLW;
        endcase
      end
      default: op = OP_NOP;
    endcase
  end

  always_comb begin
    res    = 8'h00;
    sum9   = 9'd0;
    sum5   = 5'd0;
    c_nx   = status_q[0];
    dc_nx  = status_q[1];
    upd_z  = 1'b0;
    upd_dc = 1'b0;
    upd_c  = 1'b0;
    to_f   = 1'b0;
    to_w   = 1'b0;
    skip_c = 1'b0;
    case (op)
      OP_MOVWF: begin
        res  = w_q;
        to_f = 1'b1;
      end
      OP_CLR: begin
        res = 8'h00; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_ADDWF: begin
        sum9 = {1'b0, ram_bus} + {1'b0, w_q};
        sum5 = {1'b0, ram_bus[3:0]} + {1'b0, w_q[3:0]};
        res  = sum9[7:0]; c_nx = sum9[8]; dc_nx = sum5[4];
        upd_z = 1'b1; upd_dc = 1'b1; upd_c = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      // f - W as f + ~W + 1, so a carry out means "no borrow"
      OP_SUBWF: begin
        sum9 = {1'b0, ram_bus} + {1'b0, ~w_q} + 9'd1;
        sum5 = {1'b0, ram_bus[3:0]} + {1'b0, ~w_q[3:0]} + 5'd1;
        res  = sum9[7:0]; c_nx = sum9[8]; dc_nx = sum5[4];
        upd_z = 1'b1; upd_dc = 1'b1; upd_c = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_DECF: begin
        res = ram_bus - 8'd1; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_IORWF: begin
        res = ram_bus | w_q; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_ANDWF: begin
        res = ram_bus & w_q; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_XORWF: begin
        res = ram_bus ^ w_q; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_MOVF: begin
        res = ram_bus; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_COMF: begin
        res = ~ram_bus; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_INCF: begin
        res = ram_bus + 8'd1; upd_z = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_DECFSZ: begin
        res = ram_bus - 8'd1; skip_c = (res == 8'h00); to_f = dst_d; to_w = !dst_d;
      end
      OP_INCFSZ: begin
        res = ram_bus + 8'd1; skip_c = (res == 8'h00); to_f = dst_d; to_w = !dst_d;
      end
      OP_RRF: begin
        res = {status_q[0], ram_bus[7:1]}; c_nx = ram_bus[0];
        upd_c = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_RLF: begin
        res = {ram_bus[6:0], status_q[0]}; c_nx = ram_bus[7];
        upd_c = 1'b1; to_f = dst_d; to_w = !dst_d;
      end
      OP_SWAPF: begin
        res = {ram_bus[3:0], ram_bus[7:4]}; to_f = dst_d; to_w = !dst_d;
      end
      OP_BCF: begin
        res = ram_bus & ~bit_mask; to_f = 1'b1;
      end
      OP_BSF: begin
        res = ram_bus | bit_mask; to_f = 1'b1;
      end
      OP_BTFSC: skip_c = ((ram_bus & bit_mask) == 8'h00);
      OP_BTFSS: skip_c = ((ram_bus & bit_mask) != 8'h00);
      OP_MOVLW: begin
        res = lit_k; to_w = 1'b1;
      end
      OP_IORLW: begin
        res = w_q | lit_k; upd_z = 1'b1; to_w = 1'b1;
      end
      OP_ANDLW: begin
        res = w_q & lit_k; upd_z = 1'b1; to_w = 1'b1;
      end
      OP_XORLW: begin
        res = w_q ^ lit_k; upd_z = 1'b1; to_w = 1'b1;
      end
      default: begin
        res = 8'h00;
      end
    endcase
    status_nx = {upd_z  ? (res == 8'h00) : status_q[2],
                 upd_dc ? dc_nx          : status_q[1],
                 upd_c  ? c_nx           : status_q[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= 12'h000;
      w_q      <= 8'h00;
      status_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      w_q      <= w_d;
      status_q <= status_d;
    end
  end

  // All outputs decode from state_q, so an async reset clears them in the same instant.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    w_d      = w_q;
    status_d = status_q;
    ready    = 1'b0;
    addr     = 5'd0;
    we       = 1'b0;
    alu_bus  = 8'h00;
    done     = 1'b0;
    skip     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        addr    = instr_q[4:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        addr     = instr_q[4:0];
        we       = to_f;
        alu_bus  = res;
        done     = 1'b1;
        skip     = skip_c;
        status_d = status_nx;
        if (to_w) w_d = res;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
